slave_rx_buffer: RTL and testbench



---
 rtl/slave_rx_buffer.sv | 108 ++++++++++
 tb/tb_slave_rx_buffer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/slave_rx_buffer.sv
// Accept-side receive buffer: valid/ready capture into a small FIFO that drains downstream,
// with fixed-length frame tracking that reports a signed per-frame sum.
module slave_rx_buffer #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int SUM_W     = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic [SUM_W-1:0]         frame_sum,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop;

    // ready looks only at occupancy so the master can gate its data with it
    assign ready     = level < (AW + 1)'(DEPTH);
    assign out_valid = level != '0;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign push      = valid && ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    state_t                   state, state_nxt;
    logic signed [SUM_W-1:0]  acc, acc_nxt, ext, sum_final;
    logic [CW-1:0]            cnt, cnt_nxt;
    logic                     complete;

    assign ext = SUM_W'($signed(data_in));

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        complete  = 1'b0;
        sum_final = (state == IDLE) ? ext : acc + ext;
        if (push) begin
            case (state)
                IDLE: begin
                    acc_nxt = ext;
                    cnt_nxt = CW'(1);
                    if (FRAME_LEN == 1) complete = 1'b1;
                    else                state_nxt = ACCUM;
                end
                ACCUM: begin
                    acc_nxt = acc + ext;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt + CW'(1) == CW'(FRAME_LEN)) complete = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
        if (complete) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
            frame_sum  <= '0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            frame_done <= complete;
            if (complete) frame_sum <= sum_final;
        end
    end
endmodule

// File: tb/tb_slave_rx_buffer.sv
// Directed plus random stimulus for slave_rx_buffer, checked against a queue/integer reference model.
module tb_slave_rx_buffer;
    localparam int DEPTH = 8;
    localparam int FRAME_LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  data_in = '0;
    logic        ready, out_valid, out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        frame_done;
    logic [10:0] frame_sum;
    logic [3:0]  level;

    int vectors = 0;
    int miscompares = 0;

    // reference model
    logic [7:0]  mq[$];
    int          m_cnt = 0;
    int          m_acc = 0;
    logic [10:0] m_sum = '0;
    logic        m_done = 1'b0;

    slave_rx_buffer #(.DATA_W(8), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN), .SUM_W(11)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data_in(data_in), .ready(ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .frame_done(frame_done), .frame_sum(frame_sum), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic [7:0] head;
        head = (mq.size() != 0) ? mq[0] : 8'h00;
        chk("ready", 32'(ready), 32'(mq.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("out_data", 32'(out_data), 32'(head));
        chk("level", 32'(level), 32'(mq.size()));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_sum", 32'(frame_sum), 32'(m_sum));
    endtask

    task automatic model_clear();
        mq.delete();
        m_cnt = 0; m_acc = 0; m_sum = '0; m_done = 1'b0;
    endtask

    // called at a negedge; leaves the bench at the following negedge
    task automatic step(input logic v, input logic [7:0] d, input logic ordy);
        logic m_push, m_pop;
        int   sd;
        valid = v; data_in = d; out_ready = ordy;
        #1;
        chk_all();
        m_push = v && (mq.size() < DEPTH);
        m_pop  = (mq.size() != 0) && ordy;
        @(posedge clk);
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(d);
        m_done = 1'b0;
        if (m_push) begin
            sd = (d >= 8'd128) ? int'(d) - 256 : int'(d);
            m_acc += sd;
            m_cnt++;
            if (m_cnt == FRAME_LEN) begin
                m_sum  = 11'(m_acc);
                m_done = 1'b1;
                m_acc  = 0;
                m_cnt  = 0;
            end
        end
        @(negedge clk);
    endtask

    // asynchronous reset asserted between edges, checked before any clock edge
    task automatic async_reset();
        valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_clear();
        chk_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int dones;
        // 1: reset then idle
        @(negedge clk);
        chk_all();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0);

        // 2: single transfer latency
        step(1'b1, 8'h2A, 1'b1);
        #1 chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h2A);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // 3: fill and backpressure
        for (int i = 1; i <= 10; i++) step(1'b1, 8'(i), 1'b0);
        #1 chk("full_level", 32'(level), 32'd8);
        chk("full_ready", 32'(ready), 32'd0);
        step(1'b1, 8'd9, 1'b1);
        step(1'b1, 8'd9, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        // 4: frame sums including the extremes
        async_reset();
        step(1'b1, 8'h7F, 1'b1);
        step(1'b1, 8'h7F, 1'b1);
        step(1'b1, 8'h80, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        #1 chk("sum_pos_done", 32'(frame_done), 32'd1);
        chk("sum_pos", 32'(frame_sum), 32'h07D);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h80, 1'b1);
        #1 chk("sum_neg", 32'(frame_sum), 32'h600);
        step(1'b0, 8'h00, 1'b1);
        #1 chk("sum_held", 32'(frame_sum), 32'h600);

        // 5: simultaneous push/pop at level 3 with pointer wrap
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b1);
        #1 chk("pp_level", 32'(level), 32'd3);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);

        // 6: reset mid-frame, then a fresh frame
        step(1'b1, 8'h33, 1'b0);
        step(1'b1, 8'h44, 1'b0);
        async_reset();
        dones = 0;
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 8'(i), 1'b1);
            if (frame_done) dones++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (frame_done) dones++;
        end
        chk("rst_frame_sum", 32'(frame_sum), 32'd10);
        chk("rst_one_done", 32'(dones), 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : 1));
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
